// File: rtl/unidade_controle.sv
// Multicycle control FSM for the 10-bit datapath: sequences T0..T3 strobes.
// Optional mvnz opcode (1000) enabled by defining MVNZ_EN.
module unidade_controle #(
  parameter int DIN_WAIT = 0
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Run,
  input  logic [9:0] InstIR,
  input  logic       GNZ,
  output logic       IRIn,
  output logic [7:0] RIn,
  output logic [7:0] ROut,
  output logic       AIn,
  output logic       GIn,
  output logic       GOut,
  output logic       DinOut,
  output logic [2:0] AluOp,
  output logic       Done,
  output logic [1:0] Tstep
);

  if (DIN_WAIT < 0 || DIN_WAIT > 3) begin : g_bad_wait
    $error("DIN_WAIT must be in 0..3");
  end

  typedef enum logic [1:0] {
    T0 = 2'b00,
    T1 = 2'b01,
    T2 = 2'b10,
    T3 = 2'b11
  } step_t;

  localparam logic [1:0] WMAX = DIN_WAIT[1:0];

  step_t      state, nstate;
  logic [1:0] wcnt, wcnt_n;
  logic [3:0] op;
  logic [7:0] rxh, ryh;
  logic       is_alu;

  assign op     = InstIR[9:6];
  assign rxh    = 8'b1 << InstIR[5:3];
  assign ryh    = 8'b1 << InstIR[2:0];
  assign is_alu = (op >= 4'd2) && (op <= 4'd7);
  assign Tstep  = state;

`ifndef MVNZ_EN
  logic unused_gnz;
  assign unused_gnz = GNZ;
`endif

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= T0;
      wcnt  <= 2'd0;
    end else begin
      state <= nstate;
      wcnt  <= wcnt_n;
    end
  end

  always_comb begin
    nstate = state;
    wcnt_n = wcnt;
    IRIn   = 1'b0;
    RIn    = 8'd0;
    ROut   = 8'd0;
    AIn    = 1'b0;
    GIn    = 1'b0;
    GOut   = 1'b0;
    DinOut = 1'b0;
    AluOp  = 3'b000;
    Done   = 1'b0;
    unique case (state)
      T0: begin
        IRIn = Run;
        if (Run) nstate = T1;
      end
      T1: begin
        if (op == 4'b0000) begin
          ROut = ryh;
          RIn  = rxh;
          Done = 1'b1;
        end else if (op == 4'b0001) begin
          // Hold in T1 until the Din source has had DIN_WAIT extra cycles
          if (wcnt < WMAX) begin
            wcnt_n = wcnt + 2'd1;
          end else begin
            DinOut = 1'b1;
            RIn    = rxh;
            Done   = 1'b1;
            wcnt_n = 2'd0;
          end
        end else if (is_alu) begin
          ROut   = rxh;
          AIn    = 1'b1;
          nstate = T2;
`ifdef MVNZ_EN
        end else if (op == 4'b1000) begin
          if (GNZ) begin
            ROut = ryh;
            RIn  = rxh;
          end
          Done = 1'b1;
`endif
        end else begin
          Done = 1'b1;
        end
      end
      T2: begin
        ROut   = ryh;
        GIn    = 1'b1;
        AluOp  = op[2:0] - 3'd2;
        nstate = T3;
      end
      T3: begin
        GOut = 1'b1;
        RIn  = rxh;
        Done = 1'b1;
      end
      default: nstate = T0;
    endcase
    if (Done) nstate = T0;
  end

endmodule

// File: doc/unidade_controle.md
Name: unidade_controle

Overview:
- Multicycle control FSM for the 10-bit processor datapath.
- Sits directly downstream of the instruction register. It drives the IR load strobe (IRIn), consumes the latched instruction (InstIR), and sequences register-file, accumulator A, ALU/G and Din bus strobes over steps T0..T3.
- Instruction format: opcode [9:6], Rx [5:3], Ry [2:0].

Parameters:
DIN_WAIT, 0, extra wait cycles (0..3) inside mvi T1 before Din is captured; values above 3 are a synthesis error

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high; forces state T0
Run  input  1  start request; sampled only in T0
InstIR  input  10  instruction currently held in the instruction register
GNZ  input  1  G register non-zero flag (used only with MVNZ_EN)
IRIn  output  1  load strobe to instruction register
RIn  output  8  one-hot register write enables, bit i = Ri
ROut  output  8  one-hot register bus drivers
AIn  output  1  load A
GIn  output  1  load G from ALU
GOut  output  1  G drives bus
DinOut  output  1  Din drives bus
AluOp  output  3  ALU function
Done  output  1  instruction complete (last step)
Tstep  output  2  current step, debug

Behaviour:
- State register Tstep: T0=00, T1=01, T2=10, T3=11. Wait counter is 2 bits.
- Reset asserted at any time: Tstep=00 and wait counter=0 immediately. Mid-instruction work is abandoned; no strobe is held.
- All outputs decode combinationally from Tstep, InstIR, Run, GNZ and the wait counter. Outputs not listed for a step are 0; AluOp=000 unless GIn=1.
- During reset: IRIn=Run and every other output is 0.
- T0: IRIn=Run. If Run=1, next step is T1; otherwise stay in T0. The IR captures on the same edge, so InstIR is valid from T1 on.
- Run is ignored outside T0; an instruction in progress always completes.
- Opcodes:
  - 0000 mv: T1: ROut[Ry], RIn[Rx], Done.
  - 0001 mvi: T1: if wait counter < DIN_WAIT, increment counter, stay in T1, no strobes. Otherwise DinOut, RIn[Rx], Done, and clear the counter. With DIN_WAIT=0, mvi completes in a single T1 cycle.
  - ALU ops 0010 add (AluOp 000), 0011 sub (001), 0100 or (010), 0101 slt (011), 0110 sll (100), 0111 srl (101):
    - T1: ROut[Rx], AIn.
    - T2: ROut[Ry], GIn, AluOp.
    - T3: GOut, RIn[Rx], Done.
  - Any other opcode is illegal: T1 asserts Done only, no other strobes.
- After any cycle with Done=1, next step is T0.
- Rx==Ry is legal and needs no special case (e.g., add R3,R3 doubles R3).
- Instruction latency counted from the T0 cycle in which Run is sampled:
  - mv and illegal opcodes: 2 cycles.
  - mvi: 2+DIN_WAIT cycles.
  - ALU ops: 4 cycles.
- A back-to-back instruction can start in the T0 immediately following Done.

Optional Feature:
- MVNZ_EN defined: opcode 1000 is mvnz. T1: if GNZ=1, ROut[Ry], RIn[Rx], Done; if GNZ=0, Done only. GNZ is sampled in T1.
- MVNZ_EN undefined: 1000 is illegal (Done only) and GNZ is unused.

Test Plan:
- Reset=1 mid-T2 of an add (InstIR=0010_001_010): Tstep=00 asynchronously, GIn=0 immediately, RIn=0. After Reset=0 with Run=0, the FSM stays in T0.
- Run=1 for one cycle in T0, InstIR=0000_011_101 (mv R3,R5): IRIn=1 in T0. T1: ROut=00100000, RIn=00001000, Done=1. Then T0.
- add R1,R2 (0010_001_010):
  - T1: ROut=00000010, AIn=1.
  - T2: ROut=00000100, GIn=1, AluOp=000.
  - T3: GOut=1, RIn=00000010, Done=1.
- DIN_WAIT=2, mvi R7 (0001_111_000): T1 held for 3 cycles. DinOut=0 in the first two; DinOut=1, RIn=10000000, Done=1 in the third.
- Run dropped to 0 during T2 of sub (0011_000_001): T3 still completes with Done=1, AluOp=001 seen in T2. The FSM then idles in T0 with IRIn=0.
- Opcode 1111: Done=1 in T1, all other strobes 0. With MVNZ_EN, opcode 1000 and GNZ=0 gives Done only; GNZ=1 gives RIn[Rx] and ROut[Ry].
